// File: rtl/uni_shiftreg_n.sv
// Parametrised universal shift register with hold/shift/rotate/arithmetic/load modes
// and a self-timed burst serialiser (BUSY/DONE). All state updates on the falling CLK edge.
module uni_shiftreg_n #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             SI_LO,
    input  logic             SI_HI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO_LO,
    output logic             SO_HI,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    // Next-state, next-data and handshake decode
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (EN) begin
                    case (MODE)
                        3'b000: q_s = q_r;
                        3'b001: q_s = {q_r[WIDTH-2:0], SI_LO};
                        3'b010: q_s = {SI_HI, q_r[WIDTH-1:1]};
                        3'b011: q_s = D;
                        3'b100: q_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                        3'b101: q_s = {q_r[0], q_r[WIDTH-1:1]};
                        3'b110: q_s = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                        3'b111: begin
                            q_s     = D;
                            cnt_s   = CNT_W'(WIDTH);
                            busy_s  = 1'b1;
                            state_s = ST_BURST;
                        end
                        default: q_s = q_r;
                    endcase
                end else begin
                    q_s = q_r;
                end
            end
            ST_BURST: begin
                if (EN) begin
                    q_s = {SI_HI, q_r[WIDTH-1:1]};
                    // Final shift (or a defensive zero count) ends the burst; count never wraps
                    if (cnt_r > CNT_W'(1)) begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end else begin
                        cnt_s   = {CNT_W{1'b0}};
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    q_s = q_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                q_s     = {WIDTH{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset on the falling edge
    always_ff @(negedge CLK) begin
        if (!RES) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign Q     = q_r;
    assign SO_LO = q_r[0];
    assign SO_HI = q_r[WIDTH-1];
    assign BUSY  = busy_r;
    assign DONE  = done_r;

endmodule

// File: tb/tb_uni_shiftreg_n.sv
// Self-checking bench for uni_shiftreg_n: directed scenarios plus randomized traffic
// compared against an arithmetic reference model; a second WIDTH=2 instance covers the boundary.
module tb_uni_shiftreg_n;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         res, en, si_lo, si_hi;
    logic [2:0]   mode;
    logic [W-1:0] d, q;
    logic         so_lo, so_hi, busy, done;

    logic         r2, e2, sl2, sh2;
    logic [2:0]   m2;
    logic [1:0]   d2, q2;
    logic         so_lo2, so_hi2, busy2, done2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] m_q;
    bit           m_busy, m_done;
    int           m_left;

    always #5 CLK = ~CLK;

    uni_shiftreg_n #(.WIDTH(W)) dut (
        .CLK(CLK), .RES(res), .EN(en), .MODE(mode), .SI_LO(si_lo), .SI_HI(si_hi),
        .D(d), .Q(q), .SO_LO(so_lo), .SO_HI(so_hi), .BUSY(busy), .DONE(done)
    );

    uni_shiftreg_n #(.WIDTH(2)) dut2 (
        .CLK(CLK), .RES(r2), .EN(e2), .MODE(m2), .SI_LO(sl2), .SI_HI(sh2),
        .D(d2), .Q(q2), .SO_LO(so_lo2), .SO_HI(so_hi2), .BUSY(busy2), .DONE(done2)
    );

    function automatic void model_edge();
        bit nd = 1'b0;
        if (!res) begin
            m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            if (m_busy) begin
                if (en) begin
                    m_q = (m_q >> 1) | (W'(si_hi) << (W - 1));
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        nd = 1'b1;
                    end
                end
            end else if (en) begin
                case (mode)
                    3'd1: m_q = (m_q << 1) | W'(si_lo);
                    3'd2: m_q = (m_q >> 1) | (W'(si_hi) << (W - 1));
                    3'd3: m_q = d;
                    3'd4: m_q = (m_q << 1) | (m_q >> (W - 1));
                    3'd5: m_q = (m_q >> 1) | (m_q << (W - 1));
                    3'd6: m_q = (m_q >> 1) | (m_q & (W'(1) << (W - 1)));
                    3'd7: begin m_q = d; m_left = W; m_busy = 1'b1; end
                    default: ;
                endcase
            end
            m_done = nd;
        end
    endfunction

    // Inputs are changed just after a rising edge; DUT acts on the falling edge; outputs read on the next rising edge.
    task automatic tick();
        model_edge();
        @(negedge CLK);
        @(posedge CLK);
    endtask

    task automatic test_reset();
        res = 1'b0; en = 1'b1; mode = 3'd3; d = 8'hFF; si_lo = 1'b0; si_hi = 1'b0;
        tick();
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset: q=%h busy=%b done=%b want q=00 busy=0 done=0", q, busy, done);
        end
        res = 1'b1;
    endtask

    typedef struct packed {
        logic [7:0] ld;
        logic [2:0] md;
        logic       sl;
        logic       sh;
        logic [7:0] ex;
    } vec_t;

    task automatic test_modes();
        vec_t vecs [8];
        vecs = '{
            '{8'h96, 3'd6, 1'b0, 1'b0, 8'hCB}, '{8'h96, 3'd5, 1'b0, 1'b0, 8'h4B},
            '{8'h96, 3'd2, 1'b0, 1'b0, 8'h4B}, '{8'hA5, 3'd1, 1'b1, 1'b0, 8'h4B},
            '{8'h81, 3'd4, 1'b0, 1'b0, 8'h03}, '{8'h96, 3'd2, 1'b0, 1'b1, 8'hCB},
            '{8'h5A, 3'd0, 1'b1, 1'b1, 8'h5A}, '{8'h69, 3'd6, 1'b0, 1'b0, 8'h34}
        };
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; mode = 3'd3; d = vecs[i].ld;
            tick();
            total++;
            if (q !== vecs[i].ld) begin
                bad++; $display("FAIL load %0d: q=%h want %h", i, q, vecs[i].ld);
            end
            mode = vecs[i].md; si_lo = vecs[i].sl; si_hi = vecs[i].sh; d = ~vecs[i].ld;
            tick();
            total++;
            if (q !== vecs[i].ex || so_lo !== vecs[i].ex[0] || so_hi !== vecs[i].ex[7]) begin
                bad++; $display("FAIL mode %0d op %0d: q=%h so_lo=%b so_hi=%b want q=%h", i, vecs[i].md, q, so_lo, so_hi, vecs[i].ex);
            end
        end
        si_lo = 1'b0; si_hi = 1'b0;
    endtask

    task automatic test_enable();
        en = 1'b1; mode = 3'd3; d = 8'h5A;
        tick();
        for (int m = 0; m < 8; m++) begin
            en = 1'b0; mode = 3'(m); d = 8'hFF; si_lo = 1'b1; si_hi = 1'b1;
            tick();
            total++;
            if (q !== 8'h5A || busy !== 1'b0) begin
                bad++; $display("FAIL en_hold mode %0d: q=%h busy=%b want q=5a busy=0", m, q, busy);
            end
        end
        res = 1'b0; en = 1'b0;
        tick();
        total++;
        if (q !== 8'h00) begin
            bad++; $display("FAIL reset_en0: q=%h want 00", q);
        end
        res = 1'b1; si_lo = 1'b0; si_hi = 1'b0;
    endtask

    task automatic test_burst();
        logic [7:0] seq;
        int cyc = 0;
        int dones = 0;
        en = 1'b1; mode = 3'd7; d = 8'hC3; si_hi = 1'b0;
        tick();
        d = 8'hFF;
        while (busy === 1'b1 && cyc < 40) begin
            if (cyc < 8) seq[cyc] = so_lo;
            if (done === 1'b1) dones++;
            mode = 3'($urandom);
            cyc++;
            tick();
        end
        total++;
        if (cyc !== 8) begin
            bad++; $display("FAIL burst_busy_len: %0d cycles want 8", cyc);
        end
        total++;
        if (seq !== 8'hC3) begin
            bad++; $display("FAIL burst_so_lo: sequence(lsb first)=%h want c3", seq);
        end
        total++;
        if (done !== 1'b1 || dones !== 0 || q !== 8'h00) begin
            bad++; $display("FAIL burst_end: done=%b early_dones=%0d q=%h want done=1 q=00", done, dones, q);
        end
        mode = 3'd0;
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL done_pulse_width: done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int sobad = 0;
        logic [7:0] d2nd;
        en = 1'b1; mode = 3'd7; d = 8'hF0;
        si_hi = 1'($urandom);
        tick();
        while (busy === 1'b1 && cyc < 40) begin
            if (so_lo !== m_q[0]) sobad++;
            en = !(cyc == 3 || cyc == 4);
            si_hi = 1'($urandom);
            mode = 3'($urandom);
            cyc++;
            tick();
        end
        total++;
        if (cyc !== 10 || sobad !== 0) begin
            bad++; $display("FAIL stall_burst: busy cycles=%0d so_lo errors=%0d want 10 and 0", cyc, sobad);
        end
        total++;
        if (done !== 1'b1 || q !== m_q) begin
            bad++; $display("FAIL stall_end: done=%b q=%h want done=1 q=%h", done, q, m_q);
        end
        d2nd = 8'($urandom);
        en = 1'b1; mode = 3'd7; d = d2nd;
        tick();
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== d2nd) begin
            bad++; $display("FAIL back_to_back: busy=%b done=%b q=%h want busy=1 done=0 q=%h", busy, done, q, d2nd);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            mode = 3'd0; cyc++;
            tick();
        end
        total++;
        if (cyc !== 8 || done !== 1'b1 || q !== m_q) begin
            bad++; $display("FAIL second_burst: cycles=%0d done=%b q=%h want 8 1 %h", cyc, done, q, m_q);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int dseen = 0;
        en = 1'b1; mode = 3'd7; d = 8'($urandom); si_hi = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        res = 1'b0;
        tick();
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid: q=%h busy=%b done=%b want 00 0 0", q, busy, done);
        end
        res = 1'b1; en = 1'b1; mode = 3'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) dseen++;
        end
        total++;
        if (dseen !== 0) begin
            bad++; $display("FAIL reset_mid_after: %0d cycles with busy/done high, want 0", dseen);
        end
        mode = 3'd3; d = 8'h3C;
        tick();
        total++;
        if (q !== 8'h3C) begin
            bad++; $display("FAIL reload_after_reset: q=%h want 3c", q);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            res   = ($urandom_range(0, 59) != 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 3'($urandom);
            si_lo = 1'($urandom);
            si_hi = 1'($urandom);
            d     = 8'($urandom);
            tick();
            total++;
            if (q !== m_q || so_lo !== m_q[0] || so_hi !== m_q[W-1] || busy !== m_busy || done !== m_done) begin
                bad++;
                $display("FAIL random cycle %0d: q=%h so=%b%b busy=%b done=%b want q=%h busy=%b done=%b",
                         i, q, so_hi, so_lo, busy, done, m_q, m_busy, m_done);
            end
        end
    endtask

    task automatic test_width2();
        logic [1:0] sos;
        int cyc = 0;
        res = 1'b1; en = 1'b0;
        r2 = 1'b0; e2 = 1'b1; m2 = 3'd0; sl2 = 1'b0; sh2 = 1'b1; d2 = 2'b00;
        @(negedge CLK); @(posedge CLK);
        r2 = 1'b1; m2 = 3'd7; d2 = 2'b10;
        @(negedge CLK); @(posedge CLK);
        m2 = 3'd3; d2 = 2'b00;
        while (busy2 === 1'b1 && cyc < 10) begin
            if (cyc < 2) sos[cyc] = so_lo2;
            cyc++;
            @(negedge CLK); @(posedge CLK);
        end
        total++;
        if (cyc !== 2 || sos !== 2'b10 || done2 !== 1'b1 || q2 !== 2'b11) begin
            bad++; $display("FAIL width2_burst: cycles=%0d so=%b done=%b q=%b want 2 10 1 11", cyc, sos, done2, q2);
        end
    endtask

    initial begin
        res = 1'b0; en = 1'b0; mode = 3'd0; si_lo = 1'b0; si_hi = 1'b0; d = '0;
        r2 = 1'b0; e2 = 1'b0; m2 = 3'd0; sl2 = 1'b0; sh2 = 1'b0; d2 = 2'b00;
        @(posedge CLK);
        test_reset();
        test_modes();
        test_enable();
        test_burst();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_width2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
